// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: display limits, the blank-digit
// code understood by the seven-segment driver, and the formatter FSM states.
package freq_meter_pkg;

    // Nibble code the display driver renders with all segments off.
    localparam logic [3:0] BCD_BLANK   = 4'hA;
    // Largest value an 8-digit display can show.
    localparam int         DISPLAY_MAX = 99_999_999;
    // Number of seven-segment digits on the display.
    localparam int         DIGITS      = 8;

    // Formatter sequencing: wait for a request, shift one bit per clock, publish.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } fmt_state_t;

endpackage : freq_meter_pkg

// File: rtl/freq_bcd_formatter_bcd_add3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // Pure combinational correction; inputs are always 0..9 so no wrap occurs.
    always_comb begin
        nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
    end

endmodule : bcd_add3

// File: rtl/freq_bcd_formatter.sv
// Binary-to-packed-BCD converter feeding the 8-digit seven-segment driver.
// Sequential double dabble, one input bit per clock; the published result is
// held stable between conversions so the display never sees partial data.
// Optional feature: define FREQ_LZ_BLANK_EN to replace leading zero digits
// with the blank code (digit0 is always shown).
module freq_bcd_formatter
    import freq_meter_pkg::*;
#(
    parameter int p_in_width  = 32,
    parameter int p_digits    = DIGITS,
    parameter int p_max_value = DISPLAY_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [p_in_width-1:0]   i_bin,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [4*p_digits-1:0]   o_data,
    output logic                    o_ovf,
    output logic                    o_valid
);

    localparam int AW = 4 * p_digits;
    localparam int CW = (p_in_width > 1) ? $clog2(p_in_width) : 1;
    localparam logic [p_in_width-1:0] MAX_VAL  = p_in_width'(p_max_value);
    localparam logic [CW-1:0]         LAST_BIT = CW'(p_in_width - 1);

    fmt_state_t               state_q, state_d;
    logic [p_in_width-1:0]    value_q, value_d;
    logic [AW-1:0]            acc_q, acc_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     ovf_pend_q, ovf_pend_d;
    logic [AW-1:0]            data_q, data_d;
    logic                     ovf_q, ovf_d;
    logic                     valid_q, valid_d;

    logic [AW-1:0]            acc_adj;
    logic [AW-1:0]            fmt_data;

    // Add-3 correction on every accumulator digit before each shift.
    generate
        for (genvar gi = 0; gi < p_digits; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .nib_i (acc_q[4*gi +: 4]),
                .nib_o (acc_adj[4*gi +: 4])
            );
        end
    endgenerate

`ifdef FREQ_LZ_BLANK_EN
    // Leading-zero scan from the top digit down; a digit is blank while every
    // digit above it (and itself) is zero. digit0 is never blanked.
    logic [p_digits-1:1] lead_zero;

    generate
        for (genvar gi = 0; gi < p_digits; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign fmt_data[3:0] = acc_q[3:0];
            end else begin : g_upper
                if (gi == p_digits - 1) begin : g_top
                    assign lead_zero[gi] = (acc_q[4*gi +: 4] == 4'd0);
                end else begin : g_mid
                    assign lead_zero[gi] = lead_zero[gi+1] && (acc_q[4*gi +: 4] == 4'd0);
                end
                assign fmt_data[4*gi +: 4] = lead_zero[gi] ? BCD_BLANK : acc_q[4*gi +: 4];
            end
        end
    endgenerate
`else
    // Leading zeros are shown as computed.
    assign fmt_data = acc_q;
`endif

    // Next-state and datapath control for IDLE -> SHIFT -> FORMAT -> IDLE.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    // Saturation keeps the value below 10^8, so the
                    // accumulator can never carry out of the top digit.
                    value_d    = (i_bin > MAX_VAL) ? MAX_VAL : i_bin;
                    ovf_pend_d = (i_bin > MAX_VAL);
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = {acc_adj[AW-2:0], value_q[p_in_width-1]};
                value_d = {value_q[p_in_width-2:0], 1'b0};
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = FORMAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FORMAT: begin
                data_d  = fmt_data;
                ovf_d   = ovf_pend_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            value_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_data  = data_q;
    assign o_ovf   = ovf_q;
    assign o_valid = valid_q;

endmodule : freq_bcd_formatter

// File: tb/tb_freq_bcd_formatter.sv
// Directed and randomized checks of the BCD formatter against a decimal
// reference model built from integer division.
module tb_freq_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_bin;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_ovf;
    logic        o_valid;

    int n_cmp = 0;
    int n_bad = 0;

    freq_bcd_formatter dut (
        .clk     (clk),
        .rst     (rst),
        .i_bin   (i_bin),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_ovf   (o_ovf),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of the saturated value, optionally blanked.
    function automatic logic [31:0] model_data(input logic [31:0] b);
        longint unsigned v;
        logic [31:0]     r;
        int              d [8];
        bit              started;
        v = (b > 32'd99_999_999) ? 64'd99_999_999 : 64'(b);
        for (int i = 0; i < 8; i++) begin
            d[i] = int'(v % 10);
            v    = v / 10;
        end
        r = '0;
        started = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            r[4*i +: 4] = 4'(d[i]);
`ifdef FREQ_LZ_BLANK_EN
            if (i > 0 && !started && d[i] == 0) r[4*i +: 4] = 4'hA;
`endif
            if (d[i] != 0) started = 1'b1;
        end
        return r;
    endfunction

    // Issue one request from a negedge; returns at the negedge after acceptance.
    task automatic launch(input logic [31:0] b);
        check("ready_before_req", {31'd0, o_ready}, 32'd1);
        i_bin   = b;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_bin   = $urandom;
        check("ready_low_after_accept", {31'd0, o_ready}, 32'd0);
    endtask

    // Wait for the result; optionally inject an ignored request at cycle inj.
    task automatic collect(input logic [31:0] b, input int inj);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 45) begin
            @(negedge clk);
            n++;
            if (n == inj) begin
                i_valid = 1'b1;
                i_bin   = 32'd7;
            end else begin
                i_valid = 1'b0;
            end
            if (o_valid) got = 1'b1;
        end
        i_valid = 1'b0;
        check("latency", n, 33);
        check("data", o_data, model_data(b));
        check("ovf", {31'd0, o_ovf}, {31'd0, (b > 32'd99_999_999)});
        $display("conv bin=%0d data=%h ovf=%0b latency=%0d", b, o_data, o_ovf, n);
    endtask

    task automatic convert(input logic [31:0] b);
        launch(b);
        collect(b, 0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        int          late_valid;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_bin   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_data", o_data, 32'h0);
        check("rst_ovf", {31'd0, o_ovf}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed values, including saturation boundaries.
        convert(32'd12_345_678);
        convert(32'd0);
        convert(32'd1_000);
        convert(32'd90_000_001);
        convert(32'd99_999_999);
        convert(32'd100_000_000);
        convert(32'hFFFF_FFFF);
        convert(32'd5);

        // Request during a conversion is ignored; one in the o_valid cycle is taken.
        launch(32'd42);
        collect(32'd42, 10);
        check("valid_pulse_one_cycle_pre", {31'd0, o_valid}, 32'd1);
        launch(32'd4_096);
        check("valid_dropped", {31'd0, o_valid}, 32'd0);
        collect(32'd4_096, 0);
        @(negedge clk);

        // Reset in the middle of SHIFT aborts and clears the output.
        launch(32'd87_654_321);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, o_ready}, 32'd1);
        check("abort_data", o_data, 32'h0);
        check("abort_valid", {31'd0, o_valid}, 32'd0);
        late_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid) late_valid++;
        end
        check("abort_no_pulse", late_valid, 0);
        check("abort_data_held", o_data, 32'h0);
        convert(32'd3_141_592);

        // Randomized values across small, in-range and overflow ranges.
        for (int k = 0; k < 24; k++) begin
            case (k % 3)
                0: r = $urandom_range(0, 999);
                1: r = $urandom_range(0, 99_999_999);
                default: r = $urandom;
            endcase
            convert(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_freq_bcd_formatter
